// File: rtl/uart_program_loader_if.sv
// Instruction-memory write port shared by the program loader and the memory.
//   imem_we   : one-cycle write strobe, one pulse per 32-bit word
//   imem_addr : byte address, always word aligned (the memory uses A>>2)
//   imem_wd   : write data
// master modport drives the port (the loader); slave modport receives it (the memory).
interface uart_program_loader_if;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wd;

    modport master (output imem_we, output imem_addr, output imem_wd);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wd);
endinterface

// File: rtl/uart_program_loader.sv
// Boot loader: receives a program image over UART (8N1, LSB first) and writes it
// word by word into the instruction memory, holding the core in reset until a
// complete image with a matching XOR checksum has been loaded.
// Frame: A5, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CHK.
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   i_rx        UART receive line (asynchronous, idle high)
//   imem        instruction-memory write port (master side)
//   o_cpu_reset reset request to the core, high until a valid image is loaded
//   o_load_done high once an image has loaded and passed its checksum
//   o_frame_err sticky error flag, cleared by the next 0xA5 sync byte
//
// Loader FSM:
//   state    | meaning
//   L_IDLE   | waiting for 0xA5 sync, other bytes ignored
//   L_LEN_LO | waiting for word count low byte
//   L_LEN_HI | waiting for word count high byte, length checked here
//   L_DATA   | receiving data bytes, writing a word every 4th byte
//   L_CHK    | waiting for checksum byte
//   L_DONE   | image valid, core released; 0xA5 starts a reload
//   L_ERROR  | frame rejected, core held; 0xA5 starts a new frame
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_rx,
    uart_program_loader_if.master  imem,
    output logic                   o_cpu_reset,
    output logic                   o_load_done,
    output logic                   o_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    // ---------------- rx synchronizer and edge detect ----------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

    uart_state_t   r_u_state, w_u_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit_idx, w_bit_idx_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_byte_valid, w_byte_valid_n;
    logic          r_byte_ferr, w_byte_ferr_n;
    logic [7:0]    r_byte, w_byte_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_u_state    <= U_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_ferr  <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_u_state    <= w_u_state_n;
            r_cnt        <= w_cnt_n;
            r_bit_idx    <= w_bit_idx_n;
            r_shift      <= w_shift_n;
            r_byte_valid <= w_byte_valid_n;
            r_byte_ferr  <= w_byte_ferr_n;
            r_byte       <= w_byte_n;
        end
    end

    always_comb begin
        w_u_state_n    = r_u_state;
        w_cnt_n        = r_cnt;
        w_bit_idx_n    = r_bit_idx;
        w_shift_n      = r_shift;
        w_byte_valid_n = 1'b0;
        w_byte_ferr_n  = 1'b0;
        w_byte_n       = r_byte;
        case (r_u_state)
            U_IDLE: begin
                if (w_rx_fall) begin
                    w_u_state_n = U_START;
                    w_cnt_n     = HALF_LAST;
                end
            end
            U_START: begin
                if (r_cnt == '0) begin
                    // Line back high at mid start bit: treat the edge as a glitch.
                    if (r_rx_sync) begin
                        w_u_state_n = U_IDLE;
                    end else begin
                        w_u_state_n = U_DATA;
                        w_cnt_n     = BIT_LAST;
                        w_bit_idx_n = '0;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            U_DATA: begin
                if (r_cnt == '0) begin
                    w_shift_n   = {r_rx_sync, r_shift[7:1]};
                    w_cnt_n     = BIT_LAST;
                    w_bit_idx_n = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_u_state_n = U_STOP;
                    end
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            U_STOP: begin
                if (r_cnt == '0) begin
                    w_u_state_n    = U_IDLE;
                    w_byte_n       = r_shift;
                    w_byte_valid_n = r_rx_sync;
                    w_byte_ferr_n  = ~r_rx_sync;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: w_u_state_n = U_IDLE;
        endcase
    end

    // ---------------- Loader FSM ----------------
    typedef enum logic [2:0] {
        L_IDLE, L_LEN_LO, L_LEN_HI, L_DATA, L_CHK, L_DONE, L_ERROR
    } load_state_t;

    load_state_t r_l_state, w_l_state_n;
    logic [7:0]  r_len_lo, w_len_lo_n;
    logic [8:0]  r_num_words, w_num_words_n;
    logic [8:0]  r_index, w_index_n;
    logic [1:0]  r_byte_cnt, w_byte_cnt_n;
    logic [7:0]  r_chk, w_chk_n;
    logic [31:0] r_word, w_word_n;
    logic        r_we, w_we_n;
    logic [9:0]  r_addr, w_addr_n;
    logic [31:0] r_wd, w_wd_n;
    logic        r_cpu_reset, w_cpu_reset_n;
    logic        r_load_done, w_load_done_n;
    logic        r_frame_err, w_frame_err_n;

    logic [15:0] w_len;
    logic [8:0]  w_index_inc;
    logic        w_is_sync;

    assign w_len       = {r_byte, r_len_lo};
    assign w_index_inc = r_index + 9'd1;
    assign w_is_sync   = r_byte_valid && (r_byte == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_l_state   <= L_IDLE;
            r_len_lo    <= '0;
            r_num_words <= '0;
            r_index     <= '0;
            r_byte_cnt  <= '0;
            r_chk       <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_l_state   <= w_l_state_n;
            r_len_lo    <= w_len_lo_n;
            r_num_words <= w_num_words_n;
            r_index     <= w_index_n;
            r_byte_cnt  <= w_byte_cnt_n;
            r_chk       <= w_chk_n;
            r_word      <= w_word_n;
            r_we        <= w_we_n;
            r_addr      <= w_addr_n;
            r_wd        <= w_wd_n;
            r_cpu_reset <= w_cpu_reset_n;
            r_load_done <= w_load_done_n;
            r_frame_err <= w_frame_err_n;
        end
    end

    always_comb begin
        w_l_state_n   = r_l_state;
        w_len_lo_n    = r_len_lo;
        w_num_words_n = r_num_words;
        w_index_n     = r_index;
        w_byte_cnt_n  = r_byte_cnt;
        w_chk_n       = r_chk;
        w_word_n      = r_word;
        w_we_n        = 1'b0;
        w_addr_n      = r_addr;
        w_wd_n        = r_wd;
        w_cpu_reset_n = r_cpu_reset;
        w_load_done_n = r_load_done;
        w_frame_err_n = r_frame_err;

        case (r_l_state)
            L_IDLE, L_DONE, L_ERROR: begin
                // A sync byte starts a (re)load from any resting state.
                if (w_is_sync) begin
                    w_l_state_n   = L_LEN_LO;
                    w_index_n     = '0;
                    w_byte_cnt_n  = '0;
                    w_chk_n       = '0;
                    w_cpu_reset_n = 1'b1;
                    w_load_done_n = 1'b0;
                    w_frame_err_n = 1'b0;
                end
            end
            L_LEN_LO: begin
                if (r_byte_valid) begin
                    w_len_lo_n  = r_byte;
                    w_l_state_n = L_LEN_HI;
                end
            end
            L_LEN_HI: begin
                if (r_byte_valid) begin
                    w_num_words_n = w_len[8:0];
                    if (32'(w_len) > 32'(MAX_WORDS)) begin
                        w_l_state_n   = L_ERROR;
                        w_frame_err_n = 1'b1;
                    end else if (w_len == 16'd0) begin
                        w_l_state_n = L_CHK;
                    end else begin
                        w_l_state_n = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (r_byte_valid) begin
                    // Bytes enter at the top so byte 0 ends up in bits [7:0].
                    w_word_n     = {r_byte, r_word[31:8]};
                    w_chk_n      = r_chk ^ r_byte;
                    w_byte_cnt_n = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_we_n    = 1'b1;
                        w_addr_n  = {r_index[7:0], 2'b00};
                        w_wd_n    = w_word_n;
                        w_index_n = w_index_inc;
                        if (w_index_inc == r_num_words) begin
                            w_l_state_n = L_CHK;
                        end
                    end
                end
            end
            L_CHK: begin
                if (r_byte_valid) begin
                    if (r_byte == r_chk) begin
                        w_l_state_n   = L_DONE;
                        w_load_done_n = 1'b1;
                        w_cpu_reset_n = 1'b0;
                    end else begin
                        w_l_state_n   = L_ERROR;
                        w_frame_err_n = 1'b1;
                    end
                end
            end
            default: w_l_state_n = L_IDLE;
        endcase

        // Framing errors abort a frame in progress; resting states ignore them.
        if (r_byte_ferr && (r_l_state != L_IDLE) && (r_l_state != L_DONE)) begin
            w_l_state_n   = L_ERROR;
            w_frame_err_n = 1'b1;
            w_cpu_reset_n = 1'b1;
            w_load_done_n = 1'b0;
            w_we_n        = 1'b0;
        end
    end

    assign imem.imem_we   = r_we;
    assign imem.imem_addr = r_addr;
    assign imem.imem_wd   = r_wd;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_load_done    = r_load_done;
    assign o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with CLKS_PER_BIT=4.
module tb_uart_program_loader;

    localparam int CPB = 4;

    logic clk;
    logic reset;
    logic rx;
    logic cpu_reset, load_done, frame_err;

    uart_program_loader_if bus ();

    uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (rx),
        .imem        (bus.master),
        .o_cpu_reset (cpu_reset),
        .o_load_done (load_done),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Write monitor: logs every imem_we pulse.
    int          we_total = 0;
    logic [9:0]  log_addr [64];
    logic [31:0] log_wd   [64];

    always @(negedge clk) begin
        if (bus.imem_we) begin
            if (we_total < 64) begin
                log_addr[we_total] = bus.imem_addr;
                log_wd[we_total]   = bus.imem_wd;
            end
            we_total = we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_seq(input logic [7:0] bytes [$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_we",        32'(bus.imem_we),   32'd0);
        check("rst_addr",      32'(bus.imem_addr), 32'd0);
        check("rst_wd",        bus.imem_wd,        32'd0);
        check("rst_cpu_reset", 32'(cpu_reset),     32'd1);
        check("rst_load_done", 32'(load_done),     32'd0);
        check("rst_frame_err", 32'(frame_err),     32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int base;

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        @(negedge clk);

        // Reset and noise before sync
        do_reset();
        base = we_total;
        send_seq('{8'h00, 8'h13});
        check("noise_no_write", 32'(we_total - base), 32'd0);
        check("noise_cpu_reset", 32'(cpu_reset), 32'd1);

        // Two-word load
        base = we_total;
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'h10, 8'h00, 8'hC1});
        check("two_cnt",   32'(we_total - base), 32'd2);
        check("two_addr0", 32'(log_addr[base]),   32'h000);
        check("two_wd0",   log_wd[base],          32'h00500093);
        check("two_addr1", 32'(log_addr[base+1]), 32'h004);
        check("two_wd1",   log_wd[base+1],        32'h00100113);
        check("two_done",  32'(load_done),        32'd1);
        check("two_cpu",   32'(cpu_reset),        32'd0);
        check("two_ferr",  32'(frame_err),        32'd0);

        // Bad checksum (reload from DONE)
        base = we_total;
        send_seq('{8'hA5});
        check("reload_cpu",  32'(cpu_reset), 32'd1);
        check("reload_done", 32'(load_done), 32'd0);
        send_seq('{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'h10, 8'h00, 8'hC0});
        check("badchk_cnt",  32'(we_total - base), 32'd2);
        check("badchk_ferr", 32'(frame_err), 32'd1);
        check("badchk_cpu",  32'(cpu_reset), 32'd1);
        check("badchk_done", 32'(load_done), 32'd0);
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'h10, 8'h00, 8'hC1});
        check("recover_ferr", 32'(frame_err), 32'd0);
        check("recover_done", 32'(load_done), 32'd1);

        // Oversize length 257
        base = we_total;
        send_seq('{8'hA5, 8'h01, 8'h01});
        check("big_ferr", 32'(frame_err), 32'd1);
        check("big_cnt",  32'(we_total - base), 32'd0);
        check("big_cpu",  32'(cpu_reset), 32'd1);

        // Framing error on 2nd data byte
        base = we_total;
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h11});
        check("fe_cleared", 32'(frame_err), 32'd0);
        send_byte(8'h22, 1'b0);
        repeat (4) @(negedge clk);
        check("fe_ferr", 32'(frame_err), 32'd1);
        check("fe_cnt",  32'(we_total - base), 32'd0);

        // 1-cycle glitch between sync and length is ignored
        base = we_total;
        send_seq('{8'hA5});
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        send_seq('{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22});
        check("glitch_cnt",  32'(we_total - base), 32'd1);
        check("glitch_addr", 32'(log_addr[base]), 32'h000);
        check("glitch_wd",   log_wd[base], 32'hEFBEADDE);
        check("glitch_done", 32'(load_done), 32'd1);

        // Reset mid-DATA after 6 data bytes
        base = we_total;
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66});
        check("mid_cnt", 32'(we_total - base), 32'd1);
        check("mid_wd",  log_wd[base], 32'h44332211);
        do_reset();
        base = we_total;
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08});
        check("post_cnt",  32'(we_total - base), 32'd1);
        check("post_addr", 32'(log_addr[base]), 32'h000);
        check("post_wd",   log_wd[base], 32'h12345678);
        check("post_done", 32'(load_done), 32'd1);
        check("post_cpu",  32'(cpu_reset), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
